// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave transmit engine.
// State encoding, byte width and the serial bit-select helper.
package i2c_pkg;

  localparam int I2C_BYTE_W = 8;

  typedef logic [I2C_BYTE_W-1:0] i2c_byte_t;

  typedef enum logic [2:0] {
    IDLE,
    ACK_WAIT,
    ACK_DRIVE,
    TX_BIT,
    TX_MACK
  } state_e;

  function automatic logic tx_bit(
    input i2c_byte_t b,
    input bit        lsb_first
  );
    return lsb_first ? b[0] : b[I2C_BYTE_W-1];
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser with registered edge and START/STOP pulses.
// Lines reset to 1 (bus idle) so leaving reset never fakes an edge.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic scl_dly_q, sda_dly_q;
  logic scl_s, sda_s;
  logic scl_rise_q, scl_fall_q;
  logic start_q, stop_q;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
      scl_rise_q <= scl_s & ~scl_dly_q;
      scl_fall_q <= ~scl_s & scl_dly_q;
      start_q    <= ~sda_s & sda_dly_q & scl_s;
      stop_q     <= sda_s & ~sda_dly_q & scl_s;
    end
  end

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_slave_tx.sv
// I2C slave transmit engine: ACK slot, multi-byte read from a byte
// FIFO, master ACK/NACK sampling and START/STOP abort.
module i2c_slave_tx
  import i2c_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit LSB_FIRST   = 1'b0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            i2c_scl_i,
  input  logic            i2c_sda_i,
  output logic            i2c_sda_oe_o,
  input  logic            ack_req_i,
  input  logic            rd_start_i,
  input  logic [7:0]      rd_data_i,
  input  logic            rd_valid_i,
  output logic            rd_ready_o,
  output logic            byte_done_o,
  output logic            master_ack_o,
  output logic            master_nack_o,
  output logic            underrun_o,
  output logic            bus_start_o,
  output logic            bus_stop_o,
  output logic            busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(I2C_BYTE_W);

  logic sda_s, scl_rise, scl_fall;
  logic start_det, stop_det, bus_evt;

  state_e        state_q;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  i2c_byte_t     mem_q [FIFO_DEPTH];
  i2c_byte_t     sh_q, sh_d, pop_data;
  logic [CW-1:0] cnt_q;
  logic rdst_q, oe_q;
  logic bd_q, mack_q, mnack_q, und_q;
  logic bstart_q, bstop_q;
  logic empty, full, load, pop, push;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .scl_i      (i2c_scl_i),
    .sda_i      (i2c_sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  assign bus_evt = start_det | stop_det;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // a byte is due on the fall that ends the ACK slot or the master ACK
  assign load = scl_fall && !bus_evt &&
                ((state_q == ACK_DRIVE && (rdst_q || rd_start_i)) ||
                 state_q == TX_MACK);
  assign pop        = load && !empty;
  assign rd_ready_o = (!full || pop) && !bus_evt;
  assign push       = rd_valid_i && rd_ready_o;
  assign pop_data   = empty ? '1 : mem_q[rd_ptr_q[AW-1:0]];
  assign sh_d       = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);

  always_ff @(posedge clk_i) begin
    if (reset_i || bus_evt) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= rd_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      oe_q     <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
      rdst_q   <= 1'b0;
      bd_q     <= 1'b0;
      mack_q   <= 1'b0;
      mnack_q  <= 1'b0;
      und_q    <= 1'b0;
      bstart_q <= 1'b0;
      bstop_q  <= 1'b0;
    end else begin
      bd_q     <= 1'b0;
      mack_q   <= 1'b0;
      mnack_q  <= 1'b0;
      und_q    <= 1'b0;
      bstart_q <= start_det;
      bstop_q  <= stop_det;
      if (bus_evt) begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
        rdst_q  <= 1'b0;
        cnt_q   <= '0;
      end else if (load) begin
        state_q <= TX_BIT;
        rdst_q  <= 1'b0;
        cnt_q   <= '0;
        sh_q    <= pop_data;
        oe_q    <= ~tx_bit(pop_data, LSB_FIRST);
        und_q   <= empty;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (ack_req_i) begin
              state_q <= ACK_WAIT;
              rdst_q  <= rd_start_i;
            end
          end
          ACK_WAIT: begin
            if (rd_start_i) rdst_q <= 1'b1;
            if (scl_fall) begin
              state_q <= ACK_DRIVE;
              oe_q    <= 1'b1;
            end
          end
          ACK_DRIVE: begin
            if (scl_fall) begin
              state_q <= IDLE;
              oe_q    <= 1'b0;
              rdst_q  <= 1'b0;
            end
          end
          TX_BIT: begin
            if (scl_fall) begin
              if (cnt_q == CW'(I2C_BYTE_W-1)) begin
                state_q <= TX_MACK;
                oe_q    <= 1'b0;
                bd_q    <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CW'(1);
                sh_q  <= sh_d;
                oe_q  <= ~tx_bit(sh_d, LSB_FIRST);
              end
            end
          end
          TX_MACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                mack_q <= 1'b1;
              end else begin
                mnack_q <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign i2c_sda_oe_o  = oe_q;
  assign byte_done_o   = bd_q;
  assign master_ack_o  = mack_q;
  assign master_nack_o = mnack_q;
  assign underrun_o    = und_q;
  assign bus_start_o   = bstart_q;
  assign bus_stop_o    = bstop_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_slave_tx.sv
// Directed bench for i2c_slave_tx: table of read transfers plus
// hand sequences for STOP abort, ACK-only, full FIFO and reset.
module tb_i2c_slave_tx;

  localparam int Q = 12;

  logic clk, rst;
  logic m_scl, m_sda, sda_bus;
  logic oe, ack_req, rd_start, rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic byte_done, mack, mnack, und, bstart, bstop, busy;

  int n_chk, n_pass;
  int n_bd, n_ack, n_nack, n_und, n_start, n_stop;
  logic [7:0] got [8];

  typedef struct packed {
    int             npush;
    logic [3:0][7:0] pdat;
    int             nbytes;
    logic [3:0][7:0] exp;
    int             und;
  } vec_t;

  vec_t tbl [4];

  assign sda_bus = m_sda & ~oe;

  i2c_slave_tx #(
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2),
    .LSB_FIRST   (1'b0)
  ) dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .i2c_scl_i     (m_scl),
    .i2c_sda_i     (sda_bus),
    .i2c_sda_oe_o  (oe),
    .ack_req_i     (ack_req),
    .rd_start_i    (rd_start),
    .rd_data_i     (rd_data),
    .rd_valid_i    (rd_valid),
    .rd_ready_o    (rd_ready),
    .byte_done_o   (byte_done),
    .master_ack_o  (mack),
    .master_nack_o (mnack),
    .underrun_o    (und),
    .bus_start_o   (bstart),
    .bus_stop_o    (bstop),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_done) n_bd    <= n_bd + 1;
    if (mack)      n_ack   <= n_ack + 1;
    if (mnack)     n_nack  <= n_nack + 1;
    if (und)       n_und   <= n_und + 1;
    if (bstart)    n_start <= n_start + 1;
    if (bstop)     n_stop  <= n_stop + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    rd_valid = 1'b1;
    rd_data  = d;
    @(negedge clk);
    rd_valid = 1'b0;
  endtask

  task automatic req(input logic with_rd);
    @(negedge clk);
    ack_req  = 1'b1;
    rd_start = with_rd;
    @(negedge clk);
    ack_req  = 1'b0;
    rd_start = 1'b0;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1; wq();
  endtask

  task automatic scl_low();
    if (m_scl) begin
      m_scl = 1'b0;
      wq();
    end
  endtask

  task automatic clk_bit(input logic msda, output logic oe_s);
    m_sda = msda; wq();
    m_scl = 1'b1; wq();
    oe_s  = oe;   wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic do_bytes(input int n);
    logic o;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = '0;
      for (int k = 0; k < 8; k++) begin
        clk_bit(1'b1, o);
        b = {b[6:0], ~o};
      end
      got[i] = b;
      clk_bit((i == n - 1) ? 1'b1 : 1'b0, o);
      chk("mack_slot_oe", int'(o), 0);
    end
  endtask

  task automatic run_read(input vec_t v, input bit do_start);
    int bd0 = n_bd;
    int ak0 = n_ack;
    int nk0 = n_nack;
    int un0 = n_und;
    int st0 = n_start;
    int sp0 = n_stop;
    logic o;
    if (do_start) i2c_start();
    else scl_low();
    for (int i = 0; i < v.npush; i++) push(v.pdat[i]);
    req(1'b1);
    clk_bit(1'b1, o);
    chk("pre_ack_oe", int'(o), 0);
    clk_bit(1'b1, o);
    chk("ack_slot_oe", int'(o), 1);
    do_bytes(v.nbytes);
    for (int i = 0; i < v.nbytes; i++)
      chk("tx_byte", int'(got[i]), int'(v.exp[i]));
    chk("busy_after_nack", int'(busy), 0);
    chk("byte_done_cnt", n_bd - bd0, v.nbytes);
    chk("master_ack_cnt", n_ack - ak0, v.nbytes - 1);
    chk("master_nack_cnt", n_nack - nk0, 1);
    chk("underrun_cnt", n_und - un0, v.und);
    i2c_stop();
    chk("bus_start_cnt", n_start - st0, int'(do_start));
    chk("bus_stop_cnt", n_stop - sp0, 1);
  endtask

  initial begin
    logic o;
    int k;
    bit acc;
    vec_t v;
    int sp0;
    n_chk = 0; n_pass = 0;
    n_bd = 0; n_ack = 0; n_nack = 0;
    n_und = 0; n_start = 0; n_stop = 0;

    for (int i = 0; i < 4; i++) tbl[i] = '0;
    tbl[0].npush = 1; tbl[0].pdat[0] = 8'hA5;
    tbl[0].nbytes = 1; tbl[0].exp[0] = 8'hA5; tbl[0].und = 0;
    tbl[1].npush = 3;
    tbl[1].pdat[0] = 8'h3C; tbl[1].pdat[1] = 8'hC3; tbl[1].pdat[2] = 8'h0F;
    tbl[1].nbytes = 3;
    tbl[1].exp[0] = 8'h3C; tbl[1].exp[1] = 8'hC3; tbl[1].exp[2] = 8'h0F;
    tbl[1].und = 0;
    tbl[2].npush = 0; tbl[2].nbytes = 1;
    tbl[2].exp[0] = 8'hFF; tbl[2].und = 1;
    tbl[3].npush = 2; tbl[3].pdat[0] = 8'h81; tbl[3].pdat[1] = 8'h7E;
    tbl[3].nbytes = 3;
    tbl[3].exp[0] = 8'h81; tbl[3].exp[1] = 8'h7E; tbl[3].exp[2] = 8'hFF;
    tbl[3].und = 1;

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    ack_req = 1'b0; rd_start = 1'b0; rd_valid = 1'b0; rd_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_oe", int'(oe), 0);
    chk("reset_rd_ready", int'(rd_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulses", int'({byte_done, mack, mnack, und, bstart, bstop}), 0);
    rst = 1'b0;
    wq();

    for (int i = 0; i < 4; i++) run_read(tbl[i], 1'b1);

    // STOP at bit 4 of 0x5A (bit value 1, so SDA is released)
    i2c_start();
    push(8'h5A); push(8'h11); push(8'h22);
    req(1'b1);
    clk_bit(1'b1, o);
    clk_bit(1'b1, o);
    chk("stop_ack_slot_oe", int'(o), 1);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, o);
    sp0 = n_stop;
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    chk("stop_bit4_oe", int'(oe), 0);
    m_sda = 1'b1;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!busy && k == 0) k = i;
    end
    chk("stop_latency", k, 4);
    chk("stop_oe", int'(oe), 0);
    chk("stop_pulse", n_stop - sp0, 1);
    chk("stop_rd_ready", int'(rd_ready), 1);
    v = '0; v.nbytes = 1; v.exp[0] = 8'hFF; v.und = 1;
    run_read(v, 1'b0);

    // ACK slot only, no read: one slot low then idle, byte kept
    i2c_start();
    push(8'h77);
    req(1'b0);
    clk_bit(1'b1, o);
    chk("ackonly_pre_oe", int'(o), 0);
    clk_bit(1'b1, o);
    chk("ackonly_slot_oe", int'(o), 1);
    clk_bit(1'b1, o);
    chk("ackonly_after_oe", int'(o), 0);
    chk("ackonly_busy", int'(busy), 0);
    v = '0; v.nbytes = 1; v.exp[0] = 8'h77; v.und = 0;
    run_read(v, 1'b0);

    // full FIFO, then push in the same cycle as the first pop
    i2c_start();
    push(8'h10); push(8'h20); push(8'h30);
    chk("fill3_rd_ready", int'(rd_ready), 1);
    push(8'h40);
    chk("fill4_rd_ready", int'(rd_ready), 0);
    req(1'b1);
    clk_bit(1'b1, o);
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    chk("full_ack_slot_oe", int'(oe), 1);
    wq();
    m_scl = 1'b0;
    rd_data = 8'h50;
    rd_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_ready) begin
        @(negedge clk);
        acc = 1'b1;
        break;
      end
    end
    rd_valid = 1'b0;
    chk("pushpop_accepted", int'(acc), 1);
    chk("pushpop_still_full", int'(rd_ready), 0);
    wq();
    k = n_und;
    do_bytes(5);
    chk("full_b0", int'(got[0]), 8'h10);
    chk("full_b1", int'(got[1]), 8'h20);
    chk("full_b2", int'(got[2]), 8'h30);
    chk("full_b3", int'(got[3]), 8'h40);
    chk("full_b4", int'(got[4]), 8'h50);
    chk("full_underrun", n_und - k, 0);
    i2c_stop();

    // reset in the middle of the ACK slot
    i2c_start();
    push(8'h66); push(8'h67);
    req(1'b1);
    clk_bit(1'b1, o);
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_oe", int'(oe), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_rd_ready", int'(rd_ready), 1);
    rst = 1'b0;
    wq();
    m_scl = 1'b0; wq();
    v = '0; v.nbytes = 1; v.exp[0] = 8'hFF; v.und = 1;
    run_read(v, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
